fd_multi: RTL
=============

# fd_multi

Parametrised multi-channel frequency divider and tick generator, the successor to the fixed single-channel divide-by-25,000,001 strobe. Each channel counts system clocks against its own runtime-loadable terminal count. Each channel outputs either a one-cycle strobe or a 50 % square wave. The block supplies pacing ticks to the memory-to-VGA datapath, the display refresh logic and the debug blinkers from the single board clock.

## Interface
- WIDTH, 26: counter and terminal-count width in bits.
- CHANNELS, 2: number of independent divider channels; must be at least 1.
- DEFAULT_DIV, 25000000: terminal count N loaded into every channel at reset. Must fit in WIDTH.
- CH_W, derived: max(1, clog2(CHANNELS)). Not user-set.

Ports:
- iClk  in  1  system clock; all state changes on its rising edge.
- iRst_n  in  1  asynchronous, active-low reset.
- iEn  in  CHANNELS  per-channel count enable.
- iMode  in  CHANNELS  per-channel output mode: 0 = strobe, 1 = toggle.
- iSync  in  1  phase-align pulse; clears every channel.
- iLoad  in  1  load request, sampled each cycle.
- iLoadCh  in  CH_W  channel index for the load.
- iLoadVal  in  WIDTH  new terminal count N.
- oLoadAck  out  1  one-cycle acknowledge of an accepted load.
- oTick  out  CHANNELS  per-channel tick output.

## Operation
- Per channel c, the block holds these registers:
  - rCount[c] (WIDTH bits)
  - rDiv[c] (WIDTH bits)
  - rStrobe[c]
  - rToggle[c]
- Reset (iRst_n low) applies asynchronously:
  - rCount = 0
  - rDiv = DEFAULT_DIV
  - rStrobe = 0
  - rToggle = 0
  - oLoadAck = 0
  - As a result, every oTick reads 0 during reset.
- Per-channel priority at each edge is: load/sync, then enable, then count.
- Terminal event: iEn[c] = 1 and rCount[c] == rDiv[c]. Its effects:
  - rCount → 0
  - rStrobe → 1
  - rToggle inverts
- Non-terminal cycle with iEn[c] = 1:
  - rCount increments by 1.
  - rStrobe → 0.
  - rToggle holds.
- iEn[c] = 0:
  - rCount holds.
  - rStrobe → 0.
  - rToggle holds.
  - A count parked at N does not fire until the channel is re-enabled.
- iSync = 1 clears every channel, regardless of iEn:
  - rCount → 0
  - rStrobe → 0
  - rToggle → 0
- Load accept: iLoad = 1 and iLoadCh < CHANNELS. On that edge, for the selected channel:
  - rDiv = iLoadVal
  - rCount → 0
  - rStrobe → 0
  - rToggle → 0
  - oLoadAck goes to 1 for exactly one cycle.
- Load with iLoadCh ≥ CHANNELS is ignored and oLoadAck stays 0.
- Load and sync on the same edge: both apply. The divisor updates, and all channels clear.
- oTick[c] = iMode[c] ? rToggle[c] : rStrobe[c]. This is a mux of registered bits.
  - A mode change is visible in the same cycle.
  - A mode change does not disturb the counter.
- N = 0 is legal:
  - Strobe mode: oTick is constant 1 while enabled.
  - Toggle mode: oTick toggles every clock.
- Counter arithmetic is unsigned WIDTH-bit. Because every load clears the count, the count never exceeds rDiv and never wraps.

## Timing
- Period is N+1 clocks per channel.
- Toggle mode gives a square wave with period 2(N+1).
- After reset release, or after a clear by sync or load, with iEn held high:
  - rCount equals k after edge k.
  - oTick rises after edge N+1 and repeats every N+1 edges.
  - In strobe mode it stays high for exactly 1 cycle.
- oLoadAck is high in the cycle after the accepting edge.
- New-divisor counting starts from 0 on that same edge.
- Latency from iEn rising to the first tick is (N − held count) + 1 edges.
- There is no combinational path from iLoad, iSync or iEn to oTick. iMode reaches oTick only through the output mux.

## Test plan
- **Reset and default period.** DEFAULT_DIV=4, CHANNELS=2, iEn=2'b11, iMode=0, release reset. Required: oTick[0] is high only after edges 5, 10 and 15, and the two channels are identical.
- **Toggle mode.** iMode[1]=1, N=4. Required: oTick[1] goes 0→1 after edge 5, 1→0 after edge 10, and so on (period 10).
- **Load.** iLoad with iLoadCh=1 and iLoadVal=2 at edge t. Required: oLoadAck is high for exactly the cycle after t; oTick[1] strobes after t+3, t+6 and later multiples of 3; channel 0 is undisturbed.
- **Invalid load.** CHANNELS=3 and iLoadCh=3. Required: no acknowledge and no divisor change.
- **Enable hold.** Drop iEn[0] when rCount[0]=4 (that is, N) and hold it low for 7 cycles. Required: no tick while low; a tick one edge after re-enable; the next tick after N+1 further edges.
- **Simultaneous events, N=0, and mid-operation reset.**
  - iSync together with a load on channel 0 clears both channels and sets the new N.
  - N=0 in strobe mode gives a constant high output.
  - Asserting iRst_n low mid-count zeroes all outputs immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fd_multi.sv
// rtl/fd_multi.sv - multi-channel frequency divider / tick generator
// Each channel divides iClk by (N+1) and emits a strobe or 50% square wave.
module fd_multi #(
  parameter int WIDTH       = 26,
  parameter int CHANNELS    = 2,
  parameter int DEFAULT_DIV = 25000000,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic [CHANNELS-1:0] iEn,
  input  logic [CHANNELS-1:0] iMode,
  input  logic                iSync,
  input  logic                iLoad,
  input  logic [CH_W-1:0]     iLoadCh,
  input  logic [WIDTH-1:0]    iLoadVal,
  output logic                oLoadAck,
  output logic [CHANNELS-1:0] oTick
);

  localparam logic [WIDTH-1:0] LP_DEF_DIV  = WIDTH'(DEFAULT_DIV);
  localparam logic [CH_W:0]    LP_CHANNELS = (CH_W + 1)'(CHANNELS);

  logic w_load_ok;
  logic r_load_ack;

  // Out-of-range channel indices are dropped silently, no acknowledge.
  assign w_load_ok = iLoad && ({1'b0, iLoadCh} < LP_CHANNELS);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_load_ack <= 1'b0;
    end else begin
      r_load_ack <= w_load_ok;
    end
  end

  assign oLoadAck = r_load_ack;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_div;
    logic             r_strobe;
    logic             r_toggle;
    logic             w_load_hit;

    assign w_load_hit = w_load_ok && (iLoadCh == CH_W'(c));

    always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
        r_count  <= '0;
        r_div    <= LP_DEF_DIV;
        r_strobe <= 1'b0;
        r_toggle <= 1'b0;
      end else if (iSync || w_load_hit) begin
        if (w_load_hit) begin
          r_div <= iLoadVal;
        end
        r_count  <= '0;
        r_strobe <= 1'b0;
        r_toggle <= 1'b0;
      end else if (iEn[c]) begin
        if (r_count == r_div) begin
          r_count  <= '0;
          r_strobe <= 1'b1;
          r_toggle <= ~r_toggle;
        end else begin
          r_count  <= r_count + 1'b1;
          r_strobe <= 1'b0;
        end
      end else begin
        r_strobe <= 1'b0;
      end
    end

    // Only iMode is combinational into the tick; both sources are registered.
    assign oTick[c] = iMode[c] ? r_toggle : r_strobe;
  end

endmodule
